// File: rtl/sr_crypto_unit_pkg.sv
// sr_crypto_unit_pkg: shared crypto op encoding, FSM states and GF(2^8) helpers
package sr_crypto_unit_pkg;

    localparam int MODE_W = 21;

    localparam int CRYPT_OP_AES32ESI    = 0;
    localparam int CRYPT_OP_AES32ESMI   = 1;
    localparam int CRYPT_OP_AES32DSI    = 2;
    localparam int CRYPT_OP_AES32DSMI   = 3;
    localparam int CRYPT_OP_SHA256SIG0  = 4;
    localparam int CRYPT_OP_SHA256SIG1  = 5;
    localparam int CRYPT_OP_SHA256SUM0  = 6;
    localparam int CRYPT_OP_SHA256SUM1  = 7;
    localparam int CRYPT_OP_SHA512SIG0H = 8;
    localparam int CRYPT_OP_SHA512SIG0L = 9;
    localparam int CRYPT_OP_SHA512SIG1H = 10;
    localparam int CRYPT_OP_SHA512SIG1L = 11;
    localparam int CRYPT_OP_SHA512SUM0R = 12;
    localparam int CRYPT_OP_SHA512SUM1R = 13;
    localparam int CRYPT_OP_W           = 14;
    localparam int CRYPT_BS_LSB         = 14;
    localparam int CRYPT_RSV_LSB        = 16;

    localparam logic [MODE_W-1:0] CRYPT_MODE_VOID        = '0;
    localparam logic [MODE_W-1:0] CRYPT_MODE_AES32ESI    = MODE_W'(1) << CRYPT_OP_AES32ESI;
    localparam logic [MODE_W-1:0] CRYPT_MODE_AES32ESMI   = MODE_W'(1) << CRYPT_OP_AES32ESMI;
    localparam logic [MODE_W-1:0] CRYPT_MODE_AES32DSI    = MODE_W'(1) << CRYPT_OP_AES32DSI;
    localparam logic [MODE_W-1:0] CRYPT_MODE_AES32DSMI   = MODE_W'(1) << CRYPT_OP_AES32DSMI;
    localparam logic [MODE_W-1:0] CRYPT_MODE_SHA256SIG0  = MODE_W'(1) << CRYPT_OP_SHA256SIG0;
    localparam logic [MODE_W-1:0] CRYPT_MODE_SHA256SIG1  = MODE_W'(1) << CRYPT_OP_SHA256SIG1;
    localparam logic [MODE_W-1:0] CRYPT_MODE_SHA256SUM0  = MODE_W'(1) << CRYPT_OP_SHA256SUM0;
    localparam logic [MODE_W-1:0] CRYPT_MODE_SHA256SUM1  = MODE_W'(1) << CRYPT_OP_SHA256SUM1;
    localparam logic [MODE_W-1:0] CRYPT_MODE_SHA512SIG0H = MODE_W'(1) << CRYPT_OP_SHA512SIG0H;
    localparam logic [MODE_W-1:0] CRYPT_MODE_SHA512SIG0L = MODE_W'(1) << CRYPT_OP_SHA512SIG0L;
    localparam logic [MODE_W-1:0] CRYPT_MODE_SHA512SIG1H = MODE_W'(1) << CRYPT_OP_SHA512SIG1H;
    localparam logic [MODE_W-1:0] CRYPT_MODE_SHA512SIG1L = MODE_W'(1) << CRYPT_OP_SHA512SIG1L;
    localparam logic [MODE_W-1:0] CRYPT_MODE_SHA512SUM0R = MODE_W'(1) << CRYPT_OP_SHA512SUM0R;
    localparam logic [MODE_W-1:0] CRYPT_MODE_SHA512SUM1R = MODE_W'(1) << CRYPT_OP_SHA512SUM1R;

    localparam logic [2:0] WD_SRC_CRYPT = 3'd5;

    typedef enum logic {IDLE, EXEC} cryptState_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 = a^-1 for a != 0 and maps 0 to 0, as the S-box requires
    function automatic logic [7:0] gfInv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gfMul(sq, sq);
            acc = gfMul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/sr_aes_sbox.sv
// sr_aes_sbox: AES forward/inverse S-box built from GF(2^8) inversion and the affine maps
module sr_aes_sbox
    import sr_crypto_unit_pkg::*;
(
    input  logic [7:0] dataIn,
    input  logic       inv,
    output logic [7:0] dataOut
);

    logic [7:0] preInv;
    logic [7:0] gfInverse;

    // inverse path undoes the affine map before inverting; forward path applies it after
    always_comb begin
        preInv = inv ? ({dataIn[6:0], dataIn[7]} ^ {dataIn[4:0], dataIn[7:5]} ^ {dataIn[1:0], dataIn[7:2]} ^ 8'h05) : dataIn;
        gfInverse = gfInv(preInv);
        dataOut = inv ? gfInverse :
                  (gfInverse ^ {gfInverse[6:0], gfInverse[7]} ^ {gfInverse[5:0], gfInverse[7:6]} ^
                   {gfInverse[4:0], gfInverse[7:5]} ^ {gfInverse[3:0], gfInverse[7:4]} ^ 8'h63);
    end

endmodule

// File: rtl/sr_crypto_unit.sv
// sr_crypto_unit: two-cycle RV32 scalar-crypto execution unit (AES32 and SHA-2 sigma/sum ops)
module sr_crypto_unit
    import sr_crypto_unit_pkg::*;
#(
    parameter int MODE_W = 21,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MODE_W-1:0] cryptMode,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    output logic [XLEN-1:0]   result,
    output logic              valid,
    output logic              busy,
    output logic              err
);

    cryptState_t state;
    cryptState_t stateNext;
    logic [MODE_W-1:0] modeQ;
    logic [XLEN-1:0] rs1Q;
    logic [XLEN-1:0] rs2Q;
    logic [CRYPT_OP_W-1:0] op;
    logic [1:0] bs;
    logic illegal;
    logic [7:0] sboxIn;
    logic [7:0] sboxOut;
    logic [31:0] aesMix;
    logic [31:0] opResult;

    // state register and operand capture on an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            modeQ <= '0;
            rs1Q  <= '0;
            rs2Q  <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && start) begin
                modeQ <= cryptMode;
                rs1Q  <= rs1;
                rs2Q  <= rs2;
            end
        end
    end

    // EXEC always lasts one cycle; a start seen during EXEC is dropped
    always_comb begin
        stateNext = state;
        valid = 1'b0;
        busy = 1'b0;
        if (state == EXEC) begin
            stateNext = IDLE;
            valid = 1'b1;
            busy = 1'b1;
        end else if (start) begin
            stateNext = EXEC;
            busy = 1'b1;
        end
    end

    assign op = modeQ[CRYPT_OP_W-1:0];
    assign bs = modeQ[CRYPT_BS_LSB+1:CRYPT_BS_LSB];
    assign illegal = (op == '0) || ((op & (op - 1'b1)) != '0) || (modeQ[MODE_W-1:CRYPT_RSV_LSB] != '0);
    assign sboxIn = rs2Q[8*bs +: 8];

    sr_aes_sbox uSbox (
        .dataIn (sboxIn),
        .inv    (op[CRYPT_OP_AES32DSI] | op[CRYPT_OP_AES32DSMI]),
        .dataOut(sboxOut)
    );

    // per-op datapath; op is one-hot when legal so the first match wins cleanly
    always_comb begin
        aesMix = op[CRYPT_OP_AES32ESMI] ? {gfMul(sboxOut, 8'h03), sboxOut, sboxOut, gfMul(sboxOut, 8'h02)} :
                 op[CRYPT_OP_AES32DSMI] ? {gfMul(sboxOut, 8'h0B), gfMul(sboxOut, 8'h0D), gfMul(sboxOut, 8'h09), gfMul(sboxOut, 8'h0E)} :
                 {24'b0, sboxOut};
        opResult = '0;
        if (|op[CRYPT_OP_AES32DSMI:CRYPT_OP_AES32ESI])
            opResult = rs1Q ^ rol32(aesMix, {bs, 3'b000});
        else if (op[CRYPT_OP_SHA256SIG0])
            opResult = ror32(rs1Q, 7) ^ ror32(rs1Q, 18) ^ (rs1Q >> 3);
        else if (op[CRYPT_OP_SHA256SIG1])
            opResult = ror32(rs1Q, 17) ^ ror32(rs1Q, 19) ^ (rs1Q >> 10);
        else if (op[CRYPT_OP_SHA256SUM0])
            opResult = ror32(rs1Q, 2) ^ ror32(rs1Q, 13) ^ ror32(rs1Q, 22);
        else if (op[CRYPT_OP_SHA256SUM1])
            opResult = ror32(rs1Q, 6) ^ ror32(rs1Q, 11) ^ ror32(rs1Q, 25);
        else if (op[CRYPT_OP_SHA512SIG0H] | op[CRYPT_OP_SHA512SIG0L])
            opResult = (rs1Q >> 1) ^ (rs1Q >> 7) ^ (rs1Q >> 8) ^ (rs2Q << 31) ^ (rs2Q << 24) ^
                       (op[CRYPT_OP_SHA512SIG0L] ? (rs2Q << 25) : 32'h0);
        else if (op[CRYPT_OP_SHA512SIG1H] | op[CRYPT_OP_SHA512SIG1L])
            opResult = (rs1Q << 3) ^ (rs1Q >> 6) ^ (rs1Q >> 19) ^ (rs2Q >> 29) ^ (rs2Q << 13) ^
                       (op[CRYPT_OP_SHA512SIG1L] ? (rs2Q << 26) : 32'h0);
        else if (op[CRYPT_OP_SHA512SUM0R])
            opResult = (rs1Q << 25) ^ (rs1Q << 30) ^ (rs1Q >> 28) ^ (rs2Q >> 7) ^ (rs2Q >> 2) ^ (rs2Q << 4);
        else if (op[CRYPT_OP_SHA512SUM1R])
            opResult = (rs1Q << 23) ^ (rs1Q >> 14) ^ (rs1Q >> 18) ^ (rs2Q >> 9) ^ (rs2Q << 18) ^ (rs2Q << 14);
    end

    // result is forced to zero outside EXEC and for illegal modes to keep the write-back mux clean
    assign result = (valid && !illegal) ? opResult : '0;
    assign err = valid && illegal;

endmodule

// File: tb/tb_sr_crypto_unit.sv
// tb_sr_crypto_unit: directed-vector bench for the two-cycle crypto unit
module tb_sr_crypto_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [20:0] cryptMode = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [31:0] result;
    logic        valid;
    logic        busy;
    logic        err;
    int total = 0;
    int bad = 0;

    sr_crypto_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cryptMode(cryptMode),
        .rs1      (rs1),
        .rs2      (rs2),
        .result   (result),
        .valid    (valid),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one op in IDLE, check busy in the start cycle, then land in EXEC
    task automatic issue(input string tag, input logic [20:0] m, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        cryptMode = m;
        rs1 = a;
        rs2 = b;
        #1;
        chk({tag, ".busy_start"}, {31'b0, busy}, 32'd1);
        chk({tag, ".valid_start"}, {31'b0, valid}, 32'd0);
        tick();
        start = 1'b0;
        cryptMode = '0;
        rs1 = 32'hDEAD_BEEF;
        rs2 = 32'hCAFE_F00D;
    endtask

    task automatic exec_ok(input string tag, input logic [31:0] exp);
        chk({tag, ".valid"}, {31'b0, valid}, 32'd1);
        chk({tag, ".busy"}, {31'b0, busy}, 32'd1);
        chk({tag, ".err"}, {31'b0, err}, 32'd0);
        chk({tag, ".result"}, result, exp);
    endtask

    task automatic exec_bad(input string tag);
        chk({tag, ".valid"}, {31'b0, valid}, 32'd1);
        chk({tag, ".err"}, {31'b0, err}, 32'd1);
        chk({tag, ".result"}, result, 32'd0);
    endtask

    task automatic idle_ok(input string tag);
        chk({tag, ".valid_idle"}, {31'b0, valid}, 32'd0);
        chk({tag, ".result_idle"}, result, 32'd0);
        chk({tag, ".busy_idle"}, {31'b0, busy}, 32'd0);
        chk({tag, ".err_idle"}, {31'b0, err}, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        idle_ok("reset");
        rst = 1'b0;
        tick();
        idle_ok("post_reset");

        issue("sig0", 21'h00_0010, 32'h0000_0001, 32'h0);
        exec_ok("sig0", 32'h0200_4000);
        tick();
        idle_ok("sig0");

        issue("sum0", 21'h00_0040, 32'h0000_0001, 32'h0);
        exec_ok("sum0", 32'h4008_0400);
        tick();
        issue("sig1_b2b", 21'h00_0020, 32'h0000_0001, 32'h0);
        exec_ok("sig1_b2b", 32'h0000_A000);
        tick();

        issue("sum1", 21'h00_0080, 32'h0000_0001, 32'h0);
        exec_ok("sum1", 32'h0420_0080);
        tick();

        issue("esi_bs3", 21'h00_C001, 32'h0, 32'h5300_0000);
        exec_ok("esi_bs3", 32'hED00_0000);
        tick();

        issue("dsi_bs0", 21'h00_0004, 32'h0, 32'h0);
        exec_ok("dsi_bs0", 32'h0000_0052);
        tick();

        issue("esmi_0", 21'h00_0002, 32'h0, 32'h0000_0001);
        exec_ok("esmi_0", 32'h847C_7CF8);
        tick();

        issue("esmi_f", 21'h00_0002, 32'hFFFF_FFFF, 32'h0000_0001);
        exec_ok("esmi_f", 32'h7B83_8307);
        tick();

        issue("dsmi_0", 21'h00_0008, 32'h0, 32'h0);
        exec_ok("dsmi_0", 32'h50A7_F451);
        tick();

        issue("s512sig0h", 21'h00_0100, 32'h0000_0100, 32'h0000_0001);
        exec_ok("s512sig0h", 32'h8100_0083);
        tick();

        issue("s512sig0l", 21'h00_0200, 32'h0000_0100, 32'h0000_0001);
        exec_ok("s512sig0l", 32'h8300_0083);
        tick();

        issue("ill_multi", 21'h00_0003, 32'h1234_5678, 32'h9ABC_DEF0);
        exec_bad("ill_multi");
        start = 1'b1;
        cryptMode = 21'h00_0010;
        rs1 = 32'h0000_0001;
        tick();
        start = 1'b0;
        #1;
        idle_ok("exec_start_ignored");
        tick();
        idle_ok("exec_start_ignored2");

        issue("ill_rsv", 21'h10_0010, 32'h0000_0001, 32'h0);
        exec_bad("ill_rsv");
        tick();

        issue("ill_zero", 21'h00_0000, 32'h0000_0001, 32'h0);
        exec_bad("ill_zero");
        tick();

        issue("rst_mid", 21'h00_0010, 32'h0000_0001, 32'h0);
        chk("rst_mid.valid_pre", {31'b0, valid}, 32'd1);
        rst = 1'b1;
        #1;
        idle_ok("rst_mid");
        tick();
        rst = 1'b0;
        tick();
        idle_ok("rst_released");
        issue("after_rst", 21'h00_0040, 32'h0000_0001, 32'h0);
        exec_ok("after_rst", 32'h4008_0400);
        tick();
        idle_ok("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_crypto_unit.md
Name: sr_crypto_unit

Overview:
- Execution unit for the RV32 scalar-crypto (Zkne/Zknd/Zknh) instructions, sitting directly downstream of the control unit's crypto detector/FSM.
- Consumes the decoded cryptMode word plus rs1/rs2 register data and produces the 32-bit result routed through the WD_SRC_CRYPT write-back mux.
- Timing is fixed to the controller's two-cycle crypto sequence: the first cycle is the hold cycle, and the register write happens in the second cycle.

Parameters:
- MODE_W, 21, width of cryptMode.
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  crypto instruction accepted; driven by the controller's hold (first cycle of the sequence)
- cryptMode  in  21  decoded op: [13:0] one-hot op select, [15:14] AES byte select bs, [20:16] reserved (must be 0)
- rs1  in  32  register operand 1
- rs2  in  32  register operand 2
- result  out  32  crypto result, valid while valid=1
- valid  out  1  result valid; write-back cycle
- busy  out  1  operation in flight (start accepted, result not yet retired)
- err  out  1  illegal cryptMode captured; sticky for the EXEC cycle only

Behaviour:
- Reset (async, rst=1): state=IDLE; operand/mode registers cleared; result=0, valid=0, busy=0, err=0.
- States:
  - IDLE: start=1 → capture rs1, rs2, cryptMode at the clock edge → EXEC. start=0 → stay in IDLE.
  - EXEC: valid=1, busy=1. result is computed combinationally from the registered operands. Unconditionally → IDLE at the next edge.
- busy=1 also in IDLE during the start cycle (combinational), so busy covers both controller cycles.
- Latency: start in cycle N → valid and result in cycle N+1, exactly one cycle; back-to-back start is accepted in the cycle after EXEC.
- start asserted while in EXEC is ignored; the controller cannot produce this, but the bench checks it.
- result is 0 whenever valid=0, which prevents X/garbage on the write-back mux.
- Illegal mode: op select zero or multi-hot, or reserved bits nonzero → result=0 and err=1 during EXEC.
- Op select bits (ror/rol = rotate, >>/<< = logical shift):
  - [0] aes32esi: y=sbox(rs2 byte bs); rd = rs1 ^ rol({24'b0,y}, 8*bs)
  - [1] aes32esmi: m = {3y, y, y, 2y} in GF(2^8) mod 0x11B; rd = rs1 ^ rol(m, 8*bs)
  - [2] aes32dsi: y = invsbox(byte); rd as aes32esi
  - [3] aes32dsmi: m = {0xB·y, 0xD·y, 9·y, 0xE·y}; rd = rs1 ^ rol(m, 8*bs)
  - [4] sha256sig0 = ror7^ror18^(>>3)
  - [5] sha256sig1 = ror17^ror19^(>>10)
  - [6] sha256sum0 = ror2^ror13^ror22
  - [7] sha256sum1 = ror6^ror11^ror25
  - [8] sha512sig0h = rs1>>1 ^ rs1>>7 ^ rs1>>8 ^ rs2<<31 ^ rs2<<24
  - [9] sha512sig0l = sig0h terms ^ rs2<<25
  - [10] sha512sig1h = rs1<<3 ^ rs1>>6 ^ rs1>>19 ^ rs2>>29 ^ rs2<<13
  - [11] sha512sig1l = sig1h terms ^ rs2<<26
  - [12] sha512sum0r = rs1<<25 ^ rs1<<30 ^ rs1>>28 ^ rs2>>7 ^ rs2>>2 ^ rs2<<4
  - [13] sha512sum1r = rs1<<23 ^ rs1>>14 ^ rs1>>18 ^ rs2>>9 ^ rs2<<18 ^ rs2<<14
- SHA ops operate on rs1 only where the formula uses only rs1; rs2 is ignored for those ops.
- All arithmetic is XOR/shift at 32 bits; GF multiplies use xtime chains; no carries.
- Reset asserted mid-EXEC: valid drops immediately (async) and no result is produced.

Decomposition:
- Shared header sr_cpu.vh:
  - CRYPT_OP_* bit-index constants (0..13)
  - CRYPT_BS_LSB=14
  - the CRYPT_MODE_VOID and per-op mode constants, so the detector and this unit share one encoding
  - WD_SRC_CRYPT, already shared
- Sub-module sr_aes_sbox:
  - ports: 8-bit in, inv select, 8-bit out
  - implements forward and inverse S-box via affine transform plus GF(2^8) inversion, with no 256-entry tables
  - instantiated once, fed by the registered byte-select mux.

Test Plan:
- rst=1 mid-EXEC, then released → valid=0, result=0, busy=0 immediately; next start still works normally.
- start with mode=sha256sig0, rs1=0x00000001 → next cycle valid=1, result=0x02004000; the following cycle valid=0, result=0.
- sha256sum0 with rs1=0x00000001 → result=0x40080400. Then back-to-back start in the cycle after EXEC → second result correct, no lost cycle.
- AES byte-select cases:
  - aes32esi, rs1=0, rs2=0x53000000, bs=3 → result=0xED000000
  - aes32dsi, rs1=0, rs2=0, bs=0 → result=0x00000052
- aes32esmi, rs1=0, rs2=0x00000001, bs=0 → result=0x847C7CF8. Repeat with rs1=0xFFFFFFFF → result=0x7B838307.
- Illegal mode cases (one-hot bits 0x0003, and reserved bit 20 set) → EXEC cycle has err=1, result=0, valid=1; start asserted during EXEC is ignored (no extra EXEC cycle).
